// File: rtl/multicycle_control_if.sv
// Control/status bundle between the multicycle control FSM (master) and the datapath it steers (slave).
interface multicycle_control_if #(
    parameter int CNT_W = 16
);
    logic [5:0]       Opcode;
    logic             Zero;
    logic             MemReady;
    logic             PCWrite;
    logic             IorD;
    logic             MemRead;
    logic             MemWrite;
    logic             IRWrite;
    logic             MemtoReg;
    logic             RegDst;
    logic             RegWrite;
    logic             ALUSrcA;
    logic [1:0]       ALUSrcB;
    logic [3:0]       ALUop;
    logic [1:0]       PCSource;
    logic             IllegalOp;
    logic             MemTimeout;
    logic [3:0]       State;
    logic [CNT_W-1:0] InstrCount;

    modport master (
        input  Opcode, Zero, MemReady,
        output PCWrite, IorD, MemRead, MemWrite, IRWrite, MemtoReg, RegDst, RegWrite,
               ALUSrcA, ALUSrcB, ALUop, PCSource, IllegalOp, MemTimeout, State, InstrCount
    );

    modport slave (
        output Opcode, Zero, MemReady,
        input  PCWrite, IorD, MemRead, MemWrite, IRWrite, MemtoReg, RegDst, RegWrite,
               ALUSrcA, ALUSrcB, ALUop, PCSource, IllegalOp, MemTimeout, State, InstrCount
    );
endinterface

// File: rtl/multicycle_control.sv
// Main control FSM of the multicycle datapath: sequences fetch/decode/execute/memory/writeback,
// waits on variable-latency memory with a watchdog, and counts retired instructions.
module multicycle_control #(
    parameter int CNT_W       = 16,
    parameter int MEM_TIMEOUT = 255
) (
    input  logic                 clk,
    input  logic                 rst_n,
    multicycle_control_if.master ctl
);
    // Operation codes understood by the downstream ALU control unit.
    localparam logic [3:0] ALU_ADD   = 4'b0010;
    localparam logic [3:0] ALU_SUB   = 4'b0110;
    localparam logic [3:0] ALU_FUNCT = 4'b1111;

    localparam logic [5:0] OP_RTYPE = 6'b000000;
    localparam logic [5:0] OP_LW    = 6'b100011;
    localparam logic [5:0] OP_SW    = 6'b101011;
    localparam logic [5:0] OP_BEQ   = 6'b000100;
    localparam logic [5:0] OP_J     = 6'b000010;
    localparam logic [5:0] OP_ADDI  = 6'b001000;

    localparam logic [7:0] WD_LAST = 8'(MEM_TIMEOUT - 1);

    typedef enum logic [3:0] {
        S_FETCH    = 4'd0,
        S_DECODE   = 4'd1,
        S_MEMADR   = 4'd2,
        S_MEMRD    = 4'd3,
        S_MEMWB    = 4'd4,
        S_MEMWR    = 4'd5,
        S_RTYPE_EX = 4'd6,
        S_RTYPE_WB = 4'd7,
        S_BEQ      = 4'd8,
        S_JUMP     = 4'd9,
        S_ADDI_EX  = 4'd10,
        S_ADDI_WB  = 4'd11,
        S_TRAP     = 4'd12
    } state_e;

    state_e           state_q, state_d;
    logic [7:0]       wd_q, wd_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             timeout_q, timeout_d;
    logic             waiting;

    always_comb begin
        // NOTE: every signal written here gets a default first, so no path can infer a latch.
        state_d   = state_q;
        wd_d      = '0;
        cnt_d     = cnt_q;
        timeout_d = timeout_q;
        waiting   = (state_q == S_FETCH) || (state_q == S_MEMRD) || (state_q == S_MEMWR);

        case (state_q)
            S_FETCH:    if (ctl.MemReady) state_d = S_DECODE;
            S_DECODE: begin
                case (ctl.Opcode)
                    OP_LW, OP_SW: state_d = S_MEMADR;
                    OP_RTYPE:     state_d = S_RTYPE_EX;
                    OP_BEQ:       state_d = S_BEQ;
                    OP_J:         state_d = S_JUMP;
                    OP_ADDI:      state_d = S_ADDI_EX;
                    default:      state_d = S_TRAP;
                endcase
            end
            S_MEMADR:   state_d = (ctl.Opcode == OP_SW) ? S_MEMWR : S_MEMRD;
            S_MEMRD:    if (ctl.MemReady) state_d = S_MEMWB;
            S_MEMWB:    state_d = S_FETCH;
            S_MEMWR:    if (ctl.MemReady) state_d = S_FETCH;
            S_RTYPE_EX: state_d = S_RTYPE_WB;
            S_RTYPE_WB: state_d = S_FETCH;
            S_BEQ:      state_d = S_FETCH;
            S_JUMP:     state_d = S_FETCH;
            S_ADDI_EX:  state_d = S_ADDI_WB;
            S_ADDI_WB:  state_d = S_FETCH;
            S_TRAP:     state_d = S_TRAP;
            default:    state_d = S_TRAP;
        endcase

        // A ready in the limit cycle takes the normal transition above instead of trapping.
        if (waiting && !ctl.MemReady) begin
            if (wd_q == WD_LAST) begin
                state_d   = S_TRAP;
                timeout_d = 1'b1;
            end else begin
                wd_d = wd_q + 8'd1;
            end
        end

        if ((state_d == S_FETCH) && (state_q != S_FETCH)) cnt_d = cnt_q + 1'b1;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
        if (!rst_n) begin
            state_q   <= S_FETCH;
            wd_q      <= '0;
            cnt_q     <= '0;
            timeout_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            wd_q      <= wd_d;
            cnt_q     <= cnt_d;
            timeout_q <= timeout_d;
        end
    end

    // Datapath controls decode from the state register; reset gates them straight to idle.
    always_comb begin
        ctl.PCWrite   = 1'b0;
        ctl.IorD      = 1'b0;
        ctl.MemRead   = 1'b0;
        ctl.MemWrite  = 1'b0;
        ctl.IRWrite   = 1'b0;
        ctl.MemtoReg  = 1'b0;
        ctl.RegDst    = 1'b0;
        ctl.RegWrite  = 1'b0;
        ctl.ALUSrcA   = 1'b0;
        ctl.ALUSrcB   = 2'b00;
        ctl.ALUop     = ALU_ADD;
        ctl.PCSource  = 2'b00;
        ctl.IllegalOp = 1'b0;
        if (rst_n) begin
            case (state_q)
                S_FETCH: begin
                    ctl.MemRead = 1'b1;
                    ctl.ALUSrcB = 2'b01;
                    ctl.IRWrite = ctl.MemReady;
                    ctl.PCWrite = ctl.MemReady;
                end
                S_DECODE:   ctl.ALUSrcB = 2'b11;
                S_MEMADR: begin
                    ctl.ALUSrcA = 1'b1;
                    ctl.ALUSrcB = 2'b10;
                end
                S_MEMRD: begin
                    ctl.MemRead = 1'b1;
                    ctl.IorD    = 1'b1;
                end
                S_MEMWB: begin
                    ctl.RegWrite = 1'b1;
                    ctl.MemtoReg = 1'b1;
                end
                S_MEMWR: begin
                    ctl.MemWrite = 1'b1;
                    ctl.IorD     = 1'b1;
                end
                S_RTYPE_EX: begin
                    ctl.ALUSrcA = 1'b1;
                    ctl.ALUop   = ALU_FUNCT;
                end
                S_RTYPE_WB: begin
                    ctl.RegWrite = 1'b1;
                    ctl.RegDst   = 1'b1;
                end
                S_BEQ: begin
                    ctl.ALUSrcA  = 1'b1;
                    ctl.ALUop    = ALU_SUB;
                    ctl.PCSource = 2'b01;
                    ctl.PCWrite  = ctl.Zero;
                end
                S_JUMP: begin
                    ctl.PCSource = 2'b10;
                    ctl.PCWrite  = 1'b1;
                end
                S_ADDI_EX: begin
                    ctl.ALUSrcA = 1'b1;
                    ctl.ALUSrcB = 2'b10;
                end
                S_ADDI_WB:  ctl.RegWrite = 1'b1;
                S_TRAP:     ctl.IllegalOp = 1'b1;
                default:    ;
            endcase
        end
    end

    assign ctl.State      = state_q;
    assign ctl.InstrCount = cnt_q;
    assign ctl.MemTimeout = timeout_q;
endmodule
